// File: rtl/seq_frame_gen.sv
// rtl/seq_frame_gen.sv - serial frame generator: preamble, MSB-first payload, zero guard bits
module seq_frame_gen #(
   parameter int DATA_W = 8,
   parameter int PRE_W = 3,
   parameter logic [PRE_W-1:0] PREAMBLE = 3'b101,
   parameter int GAP_LEN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              busy,
   output logic              x_out,
   output logic              frame_bit,
   output logic              done
);

   localparam int SW = PRE_W + DATA_W;
   localparam int MAXL = (PRE_W > DATA_W) ? ((PRE_W > GAP_LEN) ? PRE_W : GAP_LEN)
                                          : ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN);
   localparam int CW = $clog2(MAXL + 1);
   localparam logic [CW-1:0] PRE_LAST = CW'(PRE_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GAP_LAST = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

   typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [SW-1:0]  shreg, shreg_n;
   logic           x_n, busy_n, fb_n, done_n;
   logic [SW-1:0]  load_word;

   // Preamble and payload share one shift register so every bit leaves from the MSB.
   assign load_word = {PREAMBLE, data_in};
   assign ready = ~busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         x_out     <= 1'b0;
         busy      <= 1'b0;
         frame_bit <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         shreg     <= shreg_n;
         x_out     <= x_n;
         busy      <= busy_n;
         frame_bit <= fb_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      x_n     = x_out;
      busy_n  = busy;
      fb_n    = frame_bit;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            x_n    = 1'b0;
            busy_n = 1'b0;
            fb_n   = 1'b0;
            if (start) begin
               state_n = PRE;
               cnt_n   = '0;
               x_n     = load_word[SW-1];
               shreg_n = load_word << 1;
               busy_n  = 1'b1;
               fb_n    = 1'b1;
            end
         end
         PRE: begin
            x_n     = shreg[SW-1];
            shreg_n = shreg << 1;
            if (cnt == PRE_LAST) begin
               state_n = DATA;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (cnt == DATA_LAST) begin
               cnt_n   = '0;
               x_n     = 1'b0;
               fb_n    = 1'b0;
               shreg_n = '0;
               if (GAP_LEN > 0) begin
                  state_n = GAP;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
            end else begin
               x_n     = shreg[SW-1];
               shreg_n = shreg << 1;
               cnt_n   = cnt + CW'(1);
            end
         end
         GAP: begin
            x_n  = 1'b0;
            fb_n = 1'b0;
            if (cnt == GAP_LAST) begin
               state_n = IDLE;
               cnt_n   = '0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seq_frame_gen.sv
// tb/tb_seq_frame_gen.sv - directed-vector bench for seq_frame_gen
module tb_seq_frame_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ready, busy, x_out, frame_bit, done;
   logic       start2 = 1'b0;
   logic [3:0] data2 = 4'h0;
   logic       ready2, busy2, x2, fb2, done2;

   int n_checks = 0;
   int n_pass = 0;

   logic [31:0] xv, bv, fv, hits;
   logic [2:0]  win;
   logic        any_done;

   always #5 clk = ~clk;

   seq_frame_gen dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .ready(ready), .busy(busy), .x_out(x_out), .frame_bit(frame_bit), .done(done)
   );

   seq_frame_gen #(.DATA_W(4), .GAP_LEN(0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .data_in(data2),
      .ready(ready2), .busy(busy2), .x_out(x2), .frame_bit(fb2), .done(done2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records n cycles of outputs, first cycle in the highest used bit; smask drives start per cycle.
   task automatic capture(input int n, input logic [31:0] smask, input logic [7:0] sdata,
                          output logic [31:0] xo, output logic [31:0] bo, output logic [31:0] fo);
      xo = '0; bo = '0; fo = '0;
      for (int i = 0; i < n; i++) begin
         start = smask[i];
         if (smask[i]) data_in = sdata;
         xo = {xo[30:0], x_out};
         bo = {bo[30:0], busy};
         fo = {fo[30:0], frame_bit};
         tick();
      end
   endtask

   initial begin
      // reset state
      #3 rst = 1'b1;
      #1;
      check("rst_x", {31'd0, x_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fb", {31'd0, frame_bit}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
      tick();
      rst = 1'b0;

      // basic frame 8'hA5
      start = 1'b1; data_in = 8'hA5;
      tick();
      start = 1'b0;
      check("t1_ready_busy", {31'd0, ready}, 32'd0);
      capture(13, 32'd0, 8'h00, xv, bv, fv);
      check("t1_x", xv, 32'b1011010010100);
      check("t1_fb", fv, 32'b1111111111100);
      check("t1_busy", bv, 32'h1FFF);
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_busy_end", {31'd0, busy}, 32'd0);
      tick();
      check("t1_done_once", {31'd0, done}, 32'd0);

      // 101 detector loopback on the captured stream (overlapping match)
      win = 3'b000; hits = '0;
      for (int i = 0; i < 13; i++) begin
         win = {win[1:0], xv[12-i]};
         if (i >= 2 && win == 3'b101) hits[i] = 1'b1;
      end
      check("t2_hits", hits, 32'h424);

      // start pulses while busy are ignored
      start = 1'b1; data_in = 8'hA5;
      tick();
      start = 1'b0;
      capture(13, 32'h88, 8'hFF, xv, bv, fv);
      start = 1'b0;
      check("t3_x", xv, 32'b1011010010100);
      check("t3_busy", bv, 32'h1FFF);
      check("t3_done", {31'd0, done}, 32'd1);
      tick();

      // start held: back-to-back frames with one idle cycle
      start = 1'b1; data_in = 8'h3C;
      tick();
      capture(13, 32'h1FFF, 8'hC3, xv, bv, fv);
      check("t4_x1", xv, 32'b1010011110000);
      check("t4_busy1", bv, 32'h1FFF);
      check("t4_gap_x", {31'd0, x_out}, 32'd0);
      check("t4_gap_busy", {31'd0, busy}, 32'd0);
      check("t4_gap_done", {31'd0, done}, 32'd1);
      tick();
      capture(13, 32'd0, 8'h00, xv, bv, fv);
      check("t4_x2", xv, 32'b1011100001100);
      check("t4_busy2", bv, 32'h1FFF);
      check("t4_done2", {31'd0, done}, 32'd1);
      tick();

      // asynchronous reset during DATA bit 4
      start = 1'b1; data_in = 8'hA5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("t5_pre_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_async_x", {31'd0, x_out}, 32'd0);
      check("t5_async_busy", {31'd0, busy}, 32'd0);
      check("t5_async_fb", {31'd0, frame_bit}, 32'd0);
      tick();
      rst = 1'b0;
      any_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         any_done |= done | busy;
         tick();
      end
      check("t5_no_done", {31'd0, any_done}, 32'd0);
      start = 1'b1; data_in = 8'hA5;
      tick();
      start = 1'b0;
      capture(13, 32'd0, 8'h00, xv, bv, fv);
      check("t5_clean_x", xv, 32'b1011010010100);
      check("t5_clean_busy", bv, 32'h1FFF);
      check("t5_clean_done", {31'd0, done}, 32'd1);
      tick();

      // GAP_LEN=0, DATA_W=4 instance
      start2 = 1'b1; data2 = 4'h9;
      tick();
      start2 = 1'b0;
      xv = '0; bv = '0; fv = '0;
      for (int i = 0; i < 7; i++) begin
         xv = {xv[30:0], x2};
         bv = {bv[30:0], busy2};
         fv = {fv[30:0], fb2};
         tick();
      end
      check("t6_x", xv, 32'b1011001);
      check("t6_busy", bv, 32'h7F);
      check("t6_fb", fv, 32'h7F);
      check("t6_done", {31'd0, done2}, 32'd1);
      check("t6_end_busy", {31'd0, busy2}, 32'd0);
      tick();
      check("t6_done_once", {31'd0, done2}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
